// File: rtl/tdm_pkg.sv
// tdm_pkg -- shared state encoding, slot constants and default width for the TDM demux.
// Rev 1.0
`default_nettype none

package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  localparam int W_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr -- HUNT/RUN frame-alignment FSM, slot counter and per-slot load strobes.
// Rev 1.0
`default_nettype none

module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  input  logic       sof,
  output logic [1:0] slot,
  output logic       locked,
  output logic       sync_err,
  output logic       ld0,
  output logic       ld1,
  output logic       ld2,
  output logic       frame_done
);

  state_t     state, state_nx;
  logic [1:0] slot_nx;
  logic       err_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= SLOT0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nx;
      slot     <= slot_nx;
      sync_err <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    slot_nx    = slot;
    err_nx     = 1'b0;
    ld0        = 1'b0;
    ld1        = 1'b0;
    ld2        = 1'b0;
    frame_done = 1'b0;
    if (din_valid) begin
      if (sof) begin
        // An sof always starts a fresh frame; mid-frame it also flags lost alignment.
        ld0      = 1'b1;
        slot_nx  = SLOT1;
        state_nx = RUN;
        err_nx   = (state == RUN) && (slot != SLOT0);
      end else if (state == RUN) begin
        case (slot)
          SLOT0: begin
            err_nx   = 1'b1;
            state_nx = HUNT;
            slot_nx  = SLOT0;
          end
          SLOT1: begin
            ld1     = 1'b1;
            slot_nx = slot + 2'd1;
          end
          SLOT2: begin
            ld2     = 1'b1;
            slot_nx = slot + 2'd1;
          end
          default: begin
            frame_done = 1'b1;
            slot_nx    = SLOT0;
          end
        endcase
      end
    end
  end

  assign locked = (state == RUN);

endmodule

`default_nettype wire

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- time-division 1-to-4 demultiplexer with shadow capture and frame-wide output update.
// Rev 1.0
`default_nettype none

module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sof,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic         frame_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err
);

  logic         ld0, ld1, ld2, frame_done;
  logic [W-1:0] sh0, sh1, sh2;

  tdm_slot_ctr u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .sof        (sof),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .ld0        (ld0),
    .ld1        (ld1),
    .ld2        (ld2),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      o0          <= '0;
      o1          <= '0;
      o2          <= '0;
      o3          <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (ld0) sh0 <= din;
      if (ld1) sh1 <= din;
      if (ld2) sh2 <= din;
      // Slot-3 word bypasses the shadows so the whole frame lands in one edge.
      if (frame_done) begin
        o0 <= sh0;
        o1 <= sh1;
        o2 <= sh2;
        o3 <= din;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- directed scenarios plus randomized stream against a queue-based frame model.
// Rev 1.0
`default_nettype none

module tb_tdm_demux4;

  localparam int W = 8;
  localparam int VW = 4 * W + 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din_valid = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] o0, o1, o2, o3;
  logic         frame_valid, locked, sync_err;
  logic [1:0]   slot;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is the list of words since the last sof.
  logic [W-1:0] m_o [4];
  logic         m_fv, m_err, m_locked;
  logic [W-1:0] part [$];

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .o0          (o0),
    .o1          (o1),
    .o2          (o2),
    .o3          (o3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {o0, o1, o2, o3, frame_valid, sync_err, slot, locked};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [1:0] s;
    s = m_locked ? 2'(part.size()) : 2'd0;
    return {m_o[0], m_o[1], m_o[2], m_o[3], m_fv, m_err, s, m_locked};
  endfunction

  task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    rst_n = r; din_valid = v; sof = s; din = d;
    @(posedge clk);
    m_fv = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      for (int i = 0; i < 4; i++) m_o[i] = '0;
      m_locked = 1'b0;
      part.delete();
    end else if (v) begin
      if (s) begin
        if (part.size() != 0) m_err = 1'b1;
        part.delete();
        part.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (part.size() == 0) begin
          m_err = 1'b1;
          m_locked = 1'b0;
        end else begin
          part.push_back(d);
          if (part.size() == 4) begin
            for (int i = 0; i < 4; i++) m_o[i] = part[i];
            m_fv = 1'b1;
            part.delete();
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", dut_vec(), {VW{1'b0}});
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, (i == 0), w[i]);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL lock_step%0d: got %h required %h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({o0, o1, o2, o3, frame_valid, locked, slot} !== {32'h11223344, 1'b1, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL lock_frame: got %h%h%h%h fv=%b lk=%b slot=%0d required 11223344 fv=1 lk=1 slot=0",
               o0, o1, o2, o3, frame_valid, locked, slot);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_valid !== 1'b0 || {o0, o1, o2, o3} !== 32'h11223344) begin
      errors++;
      $display("FAIL lock_hold: got fv=%b out=%h%h%h%h required fv=0 out=11223344", frame_valid, o0, o1, o2, o3);
    end
  endtask

  task automatic test_hunting();
    logic [W-1:0] w [6] = '{8'h55, 8'h66, 8'h01, 8'h02, 8'h03, 8'h04};
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, (i == 2), w[i]);
      checks++;
      if (dut_vec() !== model_vec() || sync_err !== 1'b0 || locked !== (i >= 2)) begin
        errors++;
        $display("FAIL hunt_step%0d: got %h required %h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({o0, o1, o2, o3} !== 32'h01020304) begin
      errors++;
      $display("FAIL hunt_frame: got %h%h%h%h required 01020304", o0, o1, o2, o3);
    end
  endtask

  task automatic test_gapped();
    int pulses = 0;
    logic fv_after_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, (i == 0), 8'hA0 + 8'(i));
      if (i == 3) fv_after_last = frame_valid;
      pulses += int'(frame_valid);
      for (int g = 0; g < 3; g++) begin
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        pulses += int'(frame_valid);
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++;
          $display("FAIL gap_w%0d_g%0d: got %h required %h", i, g, dut_vec(), model_vec());
        end
      end
    end
    checks++;
    if (pulses != 1 || fv_after_last !== 1'b1 || {o0, o1, o2, o3} !== 32'hA0A1A2A3) begin
      errors++;
      $display("FAIL gap_frame: got pulses=%0d fv=%b out=%h%h%h%h required 1 1 A0A1A2A3",
               pulses, fv_after_last, o0, o1, o2, o3);
    end
  endtask

  task automatic test_early_sof();
    step(1'b1, 1'b1, 1'b1, 8'h10);
    step(1'b1, 1'b1, 1'b0, 8'h20);
    step(1'b1, 1'b1, 1'b1, 8'h90);
    checks++;
    if (sync_err !== 1'b1 || frame_valid !== 1'b0 || {o0, o1, o2, o3} !== 32'hA0A1A2A3 || slot !== 2'd1) begin
      errors++;
      $display("FAIL early_sof_err: got err=%b fv=%b out=%h%h%h%h slot=%0d required 1 0 A0A1A2A3 1",
               sync_err, frame_valid, o0, o1, o2, o3, slot);
    end
    for (int i = 1; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h90 + 8'(i));
    checks++;
    if ({o0, o1, o2, o3, frame_valid, sync_err} !== {32'h90919293, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL early_sof_frame: got %h%h%h%h fv=%b err=%b required 90919293 1 0",
               o0, o1, o2, o3, frame_valid, sync_err);
    end
  endtask

  task automatic test_missing_sof();
    step(1'b1, 1'b1, 1'b0, 8'h77);
    checks++;
    if ({sync_err, locked, slot, frame_valid} !== {1'b1, 1'b0, 2'd0, 1'b0} || {o0, o1, o2, o3} !== 32'h90919293) begin
      errors++;
      $display("FAIL missing_sof: got err=%b lk=%b slot=%0d fv=%b required 1 0 0 0", sync_err, locked, slot, frame_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 8'hC0 + 8'(i));
    checks++;
    if ({o0, o1, o2, o3, frame_valid, locked} !== {32'hC0C1C2C3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL relock: got %h%h%h%h fv=%b lk=%b required C0C1C2C3 1 1", o0, o1, o2, o3, frame_valid, locked);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 1'b1, 1'b1, 8'hD0);
    step(1'b1, 1'b1, 1'b0, 8'hD1);
    step(1'b0, 1'b1, 1'b0, 8'hD2);
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h required %h", dut_vec(), {VW{1'b0}});
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 8'h05 + 8'(i));
    checks++;
    if ({o0, o1, o2, o3, frame_valid} !== {32'h05060708, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h%h%h%h fv=%b required 05060708 1", o0, o1, o2, o3, frame_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 4) == 0), 8'($urandom));
      checks++;
      if (dut_vec() !== model_vec() || (frame_valid && sync_err)) begin
        errors++;
        $display("FAIL random_%0d: got %h required %h", n, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_o[i] = '0;
    m_fv = 1'b0;
    m_err = 1'b0;
    m_locked = 1'b0;
    test_reset();
    test_lock();
    test_hunting();
    test_gapped();
    test_early_sof();
    test_missing_sof();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division 1-to-4 demultiplexer. It receives a word stream in which four channels are interleaved, slot 0 first, with slot 0 marked by a start-of-frame flag.
- It collects one word per slot into shadow registers. When a frame is complete, it presents all four channel words together on registered outputs.
- It is the receive-side counterpart to the 4-to-1 channel selector in the logical-design library and sits directly behind that selector's serialised output.

Parameters:
- W, 8, data width of each channel word.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- din  input  W  interleaved channel word.
- din_valid  input  1  din holds a word this cycle.
- sof  input  1  start of frame; qualified by din_valid; marks the slot-0 word.
- o0  output  W  channel 0 word of the last complete frame.
- o1  output  W  channel 1 word of the last complete frame.
- o2  output  W  channel 2 word of the last complete frame.
- o3  output  W  channel 3 word of the last complete frame.
- frame_valid  output  1  one-cycle pulse: o0..o3 have just been updated.
- slot  output  2  index of the next expected slot; 0 while hunting.
- locked  output  1  high in state RUN.
- sync_err  output  1  one-cycle pulse when frame alignment is lost.

Behaviour:
- Reset (rst_n low at a clk edge):
  - o0..o3 = 0, frame_valid = 0, sync_err = 0, slot = 0, locked = 0.
  - Shadow registers sh0..sh2 = 0; state = HUNT.
  - Reset overrides every other input in the same cycle. Reset mid-frame discards the partial frame.
- Accepted word: din_valid = 1 at a clk edge. When din_valid = 0, sof and din are ignored and no state changes.
- State HUNT:
  - Accepted word with sof = 0: discarded; stay in HUNT, no pulse.
  - Accepted word with sof = 1: sh0 <= din, slot <= 1, go to RUN.
- State RUN, accepted word with sof = 0:
  - slot 1: sh1 <= din, slot <= 2.
  - slot 2: sh2 <= din, slot <= 3.
  - slot 3: o0 <= sh0, o1 <= sh1, o2 <= sh2, o3 <= din, all in the same edge; frame_valid <= 1 for one cycle; slot <= 0; stay in RUN.
  - slot 0: sync_err <= 1 pulse, word discarded, go to HUNT, slot <= 0.
- State RUN, accepted word with sof = 1:
  - slot 0: normal frame start; sh0 <= din, slot <= 1.
  - slot 1, 2 or 3: early sof. sync_err <= 1 pulse, the partial frame is discarded and o0..o3 are unchanged. This word starts a new frame (sh0 <= din, slot <= 1); stay in RUN.
- Outputs:
  - o0..o3 hold their value between frames.
  - frame_valid is high in the cycle after the edge that accepted the slot-3 word. Latency from the slot-3 word to visible outputs is 1 clk.
  - Back-to-back frames (din_valid continuously high) give one frame_valid per 4 accepted words with no dead cycles.
  - frame_valid and sync_err are never high in the same cycle.
- Gaps: din_valid may drop for any number of cycles mid-frame. There is no timeout; slot is held.
- All arithmetic on slot is a 2-bit increment; the wrap from 3 to 0 is explicit.

Decomposition:
- Shared package tdm_pkg:
  - state encoding HUNT = 1'b0, RUN = 1'b1;
  - slot constants SLOT0..SLOT3;
  - default width W_DEF = 8.
- One sub-module is natural: tdm_slot_ctr. It holds the 2-bit slot counter and the HUNT/RUN FSM, and produces the per-slot load strobes, frame_done and sync_err. The top level holds the datapath registers only.

Test Plan:
- Reset then lock: rst_n low 2 cycles, then words A0 (sof=1), A1, A2, A3 with W = 8 and values 0x11, 0x22, 0x33, 0x44 -> one cycle after 0x44: o0..o3 = 11, 22, 33, 44, frame_valid pulses once, locked = 1, slot = 0.
- Hunting discard: after reset send 0x55 and 0x66 with sof = 0, then the frame 01, 02, 03, 04 with sof on 01 -> locked stays 0 until 01; outputs = 01, 02, 03, 04; no sync_err.
- Gapped input: the frame 0xA0..0xA3 with din_valid low for 3 cycles between each word -> same result as the contiguous case; frame_valid pulses exactly once, 1 cycle after 0xA3.
- Early sof: frame 10, 20 then sof with 0x90, followed by 91, 92, 93 -> sync_err pulses after 0x90; o0..o3 keep the previous frame; then o0..o3 = 90, 91, 92, 93 with frame_valid.
- Missing sof: a locked stream sends a 5th word 0x77 with sof = 0 at slot 0 -> sync_err pulses, locked = 0, slot = 0; a following sof frame relocks.
- Reset mid-frame: after slots 0 and 1 of a frame, rst_n low 1 cycle -> all outputs 0, locked = 0; a following complete frame is captured correctly.
